// File: rtl/pdm_pkg.sv
// Shared constants, FSM state type and sample-width helper for the PDM microphone receiver.
package pdm_pkg;

    localparam int CLK_DIV_DEF = 25;
    localparam int DECIM_DEF   = 128;
    localparam int THRESH_DEF  = 32;

    typedef enum logic {
        IDLE = 1'b0,
        RUN  = 1'b1
    } pdm_state_e;

    // Width able to hold a ones count of 0..decim inclusive.
    function automatic int sw_of(input int decim);
        return $clog2(decim + 1);
    endfunction

endpackage

// File: rtl/pdm_mic_receiver_if.sv
// Microphone pins plus PCM sample/detect bus of the PDM receiver.
// slave = receiver side, master = the logic driving enable/M_DATA/detect_clr.
interface pdm_mic_receiver_if import pdm_pkg::*; #(
    parameter int DECIM = DECIM_DEF
);
    localparam int SW = sw_of(DECIM);

    logic          enable;
    logic          M_DATA;
    logic          M_CLK;
    logic          M_LRSEL;
    logic [SW-1:0] sample;
    logic          sample_valid;
    logic          sound_detect;
    logic          detect_clr;

    modport slave (
        input  enable, M_DATA, detect_clr,
        output M_CLK, M_LRSEL, sample, sample_valid, sound_detect
    );

    modport master (
        output enable, M_DATA, detect_clr,
        input  M_CLK, M_LRSEL, sample, sample_valid, sound_detect
    );

endinterface

// File: rtl/pdm_clkgen.sv
// M_CLK divider: toggles every CLK_DIV cycles while run is high, held cleared otherwise.
// rise is a registered one-cycle strobe in the first cycle M_CLK reads 1.
module pdm_clkgen import pdm_pkg::*; #(
    parameter int CLK_DIV = CLK_DIV_DEF
) (
    input  logic clk,
    input  logic rst_n,
    input  logic run,
    output logic m_clk,
    output logic rise
);
    localparam int            DW = $clog2(CLK_DIV);
    localparam logic [DW-1:0] TC = DW'(CLK_DIV - 1);

    logic [DW-1:0] div;

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            div   <= '0;
            m_clk <= 1'b0;
            rise  <= 1'b0;
        end else if (!run) begin
            div   <= '0;
            m_clk <= 1'b0;
            rise  <= 1'b0;
        end else begin
            rise <= 1'b0;
            if (div == TC) begin
                div   <= '0;
                m_clk <= ~m_clk;
                rise  <= ~m_clk;
            end else begin
                div <= div + 1'b1;
            end
        end
    end

endmodule

// File: rtl/pdm_mic_receiver.sv
// PDM microphone receiver: drives M_CLK, counts ones over DECIM bits into PCM samples.
// Optional sticky sound detector built only when PDM_LEVEL_DETECT_EN is defined.
module pdm_mic_receiver import pdm_pkg::*; #(
    parameter int CLK_DIV = CLK_DIV_DEF,
    parameter int DECIM   = DECIM_DEF,
    parameter int THRESH  = THRESH_DEF
) (
    input  logic              CLK100MHZ,
    input  logic              CPU_RESETN,
    pdm_mic_receiver_if.slave bus
);
    localparam int            SW   = sw_of(DECIM);
    localparam logic [SW-1:0] LAST = SW'(DECIM - 1);

    pdm_state_e    state;
    logic [1:0]    m_sync;
    logic [SW-1:0] acc;
    logic [SW-1:0] bit_cnt;
    logic [SW-1:0] sample_q;
    logic [SW-1:0] acc_nxt;
    logic          valid_q;
    logic          run;
    logic          m_clk;
    logic          rise;
    logic          win_end;

    // Gating with enable stops M_CLK on the same edge that leaves RUN.
    assign run     = (state == RUN) && bus.enable;
    assign acc_nxt = acc + SW'(m_sync[1]);
    assign win_end = run && rise && (bit_cnt == LAST);

    pdm_clkgen #(.CLK_DIV(CLK_DIV)) u_clkgen (
        .clk   (CLK100MHZ),
        .rst_n (CPU_RESETN),
        .run   (run),
        .m_clk (m_clk),
        .rise  (rise)
    );

    always_ff @(posedge CLK100MHZ or negedge CPU_RESETN) begin
        if (!CPU_RESETN) m_sync <= 2'b00;
        else             m_sync <= {m_sync[0], bus.M_DATA};
    end

    always_ff @(posedge CLK100MHZ or negedge CPU_RESETN) begin
        if (!CPU_RESETN) begin
            state    <= IDLE;
            acc      <= '0;
            bit_cnt  <= '0;
            sample_q <= '0;
            valid_q  <= 1'b0;
        end else begin
            valid_q <= 1'b0;
            case (state)
                IDLE: begin
                    acc     <= '0;
                    bit_cnt <= '0;
                    if (bus.enable) state <= RUN;
                end
                RUN: begin
                    if (!bus.enable) begin
                        state   <= IDLE;
                        acc     <= '0;
                        bit_cnt <= '0;
                    end else if (rise) begin
                        if (bit_cnt == LAST) begin
                            sample_q <= acc_nxt;
                            valid_q  <= 1'b1;
                            acc      <= '0;
                            bit_cnt  <= '0;
                        end else begin
                            acc     <= acc_nxt;
                            bit_cnt <= bit_cnt + 1'b1;
                        end
                    end
                end
                default: state <= IDLE;
            endcase
        end
    end

    assign bus.M_CLK        = m_clk;
    assign bus.M_LRSEL      = 1'b0;
    assign bus.sample       = sample_q;
    assign bus.sample_valid = valid_q;

`ifdef PDM_LEVEL_DETECT_EN
    localparam logic signed [SW:0] HALF = (SW+1)'(DECIM / 2);
    localparam logic [SW:0]        THR  = (SW+1)'(THRESH);

    logic signed [SW:0] diff;
    logic [SW:0]        amp;
    logic               det_q;

    // Judged on the value being loaded into sample so the flag rises with sample_valid.
    assign diff = $signed({1'b0, acc_nxt}) - HALF;
    assign amp  = diff[SW] ? $unsigned(-diff) : $unsigned(diff);

    always_ff @(posedge CLK100MHZ or negedge CPU_RESETN) begin
        if (!CPU_RESETN)                 det_q <= 1'b0;
        else if (win_end && (amp > THR)) det_q <= 1'b1;
        else if (bus.detect_clr)         det_q <= 1'b0;
    end

    assign bus.sound_detect = det_q;
`else
    localparam int unused_thresh = THRESH;
    logic unused_sig;

    assign unused_sig       = bus.detect_clr ^ win_end;
    assign bus.sound_detect = 1'b0;
`endif

endmodule

// File: tb/tb_pdm_mic_receiver.sv
// Scoreboard bench for pdm_mic_receiver: random/patterned PDM windows, expected samples
// and timing from window arithmetic, checked by an independent monitor on sample_valid.
module tb_pdm_mic_receiver;
    import pdm_pkg::*;

    localparam int CLK_DIV = CLK_DIV_DEF;
    localparam int DECIM   = DECIM_DEF;
    localparam int THRESH  = THRESH_DEF;
    localparam int FIRST   = CLK_DIV * (2 * DECIM - 1) + 1;
    localparam int PERIOD  = 2 * CLK_DIV * DECIM;
    localparam int M_ONES = 0, M_ZEROS = 1, M_ALT = 2, M_RAND = 3;
`ifdef PDM_LEVEL_DETECT_EN
    localparam bit DET_EN = 1'b1;
`else
    localparam bit DET_EN = 1'b0;
`endif

    typedef struct {
        int edge_no;
        int smp;
        bit sd;
    } exp_t;

    logic clk   = 1'b0;
    logic rst_n = 1'b0;

    pdm_mic_receiver_if #(.DECIM(DECIM)) bus ();

    pdm_mic_receiver #(.CLK_DIV(CLK_DIV), .DECIM(DECIM), .THRESH(THRESH)) dut (
        .CLK100MHZ  (clk),
        .CPU_RESETN (rst_n),
        .bus        (bus)
    );

    always #5 clk = ~clk;

    int   cyc = 0;
    int   errors = 0;
    int   checks = 0;
    int   t0 = 0;
    int   win = 0;
    int   last_smp = 0;
    int   clr_edge = 0;
    bit   model_sd = 1'b0;
    exp_t sbq[$];

    // cyc equals the index of the next rising edge when read at a falling edge.
    always @(posedge clk) cyc <= cyc + 1;

    task automatic summary();
        $display("Result: errors=%0d of %0d checks", errors, checks);
    endtask

    task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s: got %0d expected %0d", name, act, exp);
        end
    endtask

    task automatic wait_mclk(input logic lvl);
        int n = 0;
        while (bus.M_CLK !== lvl && n < 3 * CLK_DIV + 4) begin
            @(negedge clk);
            n++;
        end
        if (bus.M_CLK !== lvl) begin
            checks++;
            errors++;
            $display("FAIL mclk_timeout: M_CLK=%b wanted %b at edge %0d", bus.M_CLK, lvl, cyc);
            summary();
            $finish;
        end
    endtask

    task automatic gen_bits(input int mode, output logic [DECIM-1:0] wb);
        int dens = int'($urandom_range(100, 0));
        for (int i = 0; i < DECIM; i++) begin
            case (mode)
                M_ONES:  wb[i] = 1'b1;
                M_ZEROS: wb[i] = 1'b0;
                M_ALT:   wb[i] = i[0];
                default: wb[i] = (int'($urandom_range(99, 0)) < dens);
            endcase
        end
    endtask

    // Expected result of one full window, from the ones count and the detect rule.
    task automatic push_exp(input logic [DECIM-1:0] wb);
        exp_t e;
        int   s = $countones(wb);
        bit   over = ((s - DECIM / 2) > THRESH) || ((DECIM / 2 - s) > THRESH);
        model_sd  = model_sd | over;
        e.edge_no = t0 + FIRST + win * PERIOD;
        e.smp     = s;
        e.sd      = DET_EN & model_sd;
        win++;
        sbq.push_back(e);
    endtask

    // Microphone side: present each bit while M_CLK is low, advance after the fall.
    task automatic drive_bits(input logic [DECIM-1:0] wb, input int n);
        for (int i = 0; i < n; i++) begin
            bus.M_DATA = wb[i];
            wait_mclk(1'b1);
            wait_mclk(1'b0);
        end
    endtask

    task automatic pulse_clr();
        while (cyc != clr_edge) @(negedge clk);
        bus.detect_clr = 1'b1;
        @(negedge clk);
        bus.detect_clr = 1'b0;
    endtask

    task automatic run_window(input int mode, input bit clr_at_valid);
        logic [DECIM-1:0] wb;
        gen_bits(mode, wb);
        push_exp(wb);
        if (clr_at_valid) begin
            clr_edge = sbq[$].edge_no;
            fork
                pulse_clr();
            join_none
        end
        drive_bits(wb, DECIM);
        last_smp = $countones(wb);
    endtask

    task automatic clear_alone();
        bus.detect_clr = 1'b1;
        @(negedge clk);
        bus.detect_clr = 1'b0;
        model_sd = 1'b0;
        chk("clear_alone_sd", bus.sound_detect, 0);
    endtask

    task automatic start_run();
        bus.enable = 1'b1;
        t0  = cyc;
        win = 0;
    endtask

    always @(negedge clk) begin : mon
        exp_t e;
        if (rst_n && bus.sample_valid === 1'b1) begin
            if (sbq.size() == 0) begin
                checks++;
                errors++;
                $display("FAIL stray_valid: pulse at edge %0d sample=%0d, none expected", cyc - 1, bus.sample);
            end else begin
                e = sbq.pop_front();
                chk("valid_edge", cyc - 1, e.edge_no);
                chk("sample", bus.sample, e.smp);
                chk("sound_detect", bus.sound_detect, e.sd);
            end
        end
    end

    initial begin
        #20_000_000;
        errors++;
        $display("FAIL watchdog: simulation did not finish at edge %0d", cyc);
        summary();
        $fatal(1);
    end

    initial begin
        logic [DECIM-1:0] wb;
        bit               saved;

        bus.enable     = 1'b0;
        bus.M_DATA     = 1'b0;
        bus.detect_clr = 1'b0;
        repeat (4) @(negedge clk);
        chk("rst_mclk", bus.M_CLK, 0);
        chk("rst_lrsel", bus.M_LRSEL, 0);
        chk("rst_sample", bus.sample, 0);
        chk("rst_valid", bus.sample_valid, 0);
        chk("rst_sd", bus.sound_detect, 0);
        rst_n = 1'b1;
        repeat (3) @(negedge clk);

        start_run();
        run_window(M_ONES, 1'b0);
        run_window(M_ONES, 1'b0);
        clear_alone();
        run_window(M_ZEROS, 1'b0);
        clear_alone();
        run_window(M_ALT, 1'b0);
        run_window(M_ONES, 1'b1);
        run_window(M_RAND, 1'b0);

        // Drop enable while M_CLK is high on the 101st bit of a window.
        saved = model_sd;
        gen_bits(M_RAND, wb);
        push_exp(wb);
        drive_bits(wb, 100);
        bus.M_DATA = wb[100];
        wait_mclk(1'b1);
        bus.enable = 1'b0;
        @(negedge clk);
        chk("abort_mclk", bus.M_CLK, 0);
        void'(sbq.pop_back());
        model_sd = saved;
        repeat (300) @(negedge clk);
        chk("idle_mclk", bus.M_CLK, 0);
        chk("abort_sample_hold", bus.sample, last_smp);
        chk("abort_sd_hold", bus.sound_detect, DET_EN & model_sd);

        start_run();
        run_window(M_RAND, 1'b0);

        // Reset in the middle of a window.
        gen_bits(M_RAND, wb);
        push_exp(wb);
        drive_bits(wb, 30);
        rst_n = 1'b0;
        #1;
        chk("midrst_mclk", bus.M_CLK, 0);
        chk("midrst_sample", bus.sample, 0);
        chk("midrst_valid", bus.sample_valid, 0);
        chk("midrst_sd", bus.sound_detect, 0);
        void'(sbq.pop_back());
        model_sd = 1'b0;
        repeat (3) @(negedge clk);
        rst_n = 1'b1;
        start_run();
        run_window(M_ONES, 1'b0);

        bus.enable = 1'b0;
        repeat (20) @(negedge clk);
        chk("sb_drained", sbq.size(), 0);
        summary();
        $finish;
    end

endmodule
